// File: rtl/transition_controller_if.sv
// Signal bundle between the game-flow controller and the level/renderer side.
// The master drives the requests and the slave (the controller) drives the status outputs.
interface transition_controller_if;
    logic       start_button;
    logic       frame_tick;
    logic       win_req;
    logic       lose_req;
    logic [1:0] level_idx;
    logic       level_reset;
    logic       input_enable;
    logic       blank_screen;
    logic       show_hearts;
    logic [2:0] lives;
    logic       req_ack;
    logic       game_over;
    logic       game_won;
    logic [2:0] fsm_state;

    modport master (
        output start_button, frame_tick, win_req, lose_req,
        input  level_idx, level_reset, input_enable, blank_screen, show_hearts,
        input  lives, req_ack, game_over, game_won, fsm_state
    );

    modport slave (
        input  start_button, frame_tick, win_req, lose_req,
        output level_idx, level_reset, input_enable, blank_screen, show_hearts,
        output lives, req_ack, game_over, game_won, fsm_state
    );
endinterface

// File: rtl/transition_controller.sv
// Game-flow sequencer: IDLE -> LOAD -> PLAY -> HOLD -> (LOAD | OVER | WON).
// Optional macro TRANSITION_LIFE_BONUS_EN awards one life per completed level.
module transition_controller #(
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 7,
    parameter int NUM_LEVELS   = 3,
    parameter int HOLD_FRAMES  = 60,
    parameter int RESET_CYCLES = 4
) (
    input logic vga_clock,
    input logic reset,
    transition_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        HOLD = 3'd3,
        OVER = 3'd4,
        WON  = 3'd5
    } state_t;

    localparam logic [2:0] START_L   = 3'((START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES);
    localparam logic [1:0] LAST_LVL  = 2'(NUM_LEVELS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0] LOAD_LAST = 4'(RESET_CYCLES - 1);

    state_t     state;
    logic [1:0] level_idx;
    logic [2:0] lives;
    logic       level_reset;
    logic       input_enable;
    logic       blank_screen;
    logic       show_hearts;
    logic       req_ack;
    logic       game_over;
    logic       game_won;
    logic [7:0] frame_cnt;
    logic [3:0] cycle_cnt;
    logic       last_win;

    // Handshake: win_req/lose_req are level requests that are only accepted
    // while in PLAY; acceptance is signalled by req_ack high for exactly the
    // one cycle following the accepting edge, and the level must drop its
    // request by then. Requests in any other state are dropped silently.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state        <= IDLE;
            level_idx    <= 2'd0;
            lives        <= START_L;
            level_reset  <= 1'b1;
            input_enable <= 1'b0;
            blank_screen <= 1'b0;
            show_hearts  <= 1'b0;
            req_ack      <= 1'b0;
            game_over    <= 1'b0;
            game_won     <= 1'b0;
            frame_cnt    <= 8'd0;
            cycle_cnt    <= 4'd0;
            last_win     <= 1'b0;
        end else begin
            req_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.start_button) begin
                        state        <= LOAD;
                        level_idx    <= 2'd0;
                        lives        <= START_L;
                        level_reset  <= 1'b1;
                        blank_screen <= 1'b1;
                        cycle_cnt    <= 4'd0;
                    end
                end
                LOAD: begin
                    if (cycle_cnt == LOAD_LAST) begin
                        state        <= PLAY;
                        level_reset  <= 1'b0;
                        input_enable <= 1'b1;
                        blank_screen <= 1'b0;
                        show_hearts  <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 4'd1;
                    end
                end
                PLAY: begin
                    if (bus.win_req || bus.lose_req) begin
                        state        <= HOLD;
                        req_ack      <= 1'b1;
                        input_enable <= 1'b0;
                        blank_screen <= 1'b1;
                        show_hearts  <= 1'b1;
                        frame_cnt    <= 8'd0;
                        last_win     <= bus.win_req;
                        // Win dominates a simultaneous lose, so no life is lost.
                        if (bus.win_req) begin
`ifdef TRANSITION_LIFE_BONUS_EN
                            if (lives < 3'(MAX_LIVES)) lives <= lives + 3'd1;
`endif
                        end else if (lives != 3'd0) begin
                            lives <= lives - 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt == HOLD_LAST) begin
                            frame_cnt <= 8'd0;
                            cycle_cnt <= 4'd0;
                            if (last_win && level_idx == LAST_LVL) begin
                                state        <= WON;
                                game_won     <= 1'b1;
                                blank_screen <= 1'b0;
                                show_hearts  <= 1'b0;
                            end else if (!last_win && lives == 3'd0) begin
                                state        <= OVER;
                                game_over    <= 1'b1;
                                blank_screen <= 1'b0;
                                show_hearts  <= 1'b0;
                            end else begin
                                state       <= LOAD;
                                level_reset <= 1'b1;
                                show_hearts <= 1'b0;
                                if (last_win) level_idx <= level_idx + 2'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                OVER, WON: begin
                    if (!bus.start_button) begin
                        state       <= IDLE;
                        game_over   <= 1'b0;
                        game_won    <= 1'b0;
                        level_reset <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.level_idx    = level_idx;
    assign bus.level_reset  = level_reset;
    assign bus.input_enable = input_enable;
    assign bus.blank_screen = blank_screen;
    assign bus.show_hearts  = show_hearts;
    assign bus.lives        = lives;
    assign bus.req_ack      = req_ack;
    assign bus.game_over    = game_over;
    assign bus.game_won     = game_won;
    assign bus.fsm_state    = state;

endmodule
